// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one write port and one read port of an 8x8 memory
// between two clients; clears the memory after reset or clear. Grant is combinational,
// commands issue one cycle later, read data returns two cycles after grant.
module mem_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    input  logic              c0_req,
    input  logic              c1_req,
    input  logic              c0_we,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c0_gnt,
    output logic              c1_gnt,
    output logic              c0_rvalid,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr_w,
    output logic [ADDR_W-1:0] mem_addr_r,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last;
    logic              wr_q;
    logic              rd_q;
    logic [ADDR_W-1:0] addr_w_q;
    logic [ADDR_W-1:0] addr_r_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        tag_vld;
    logic [1:0]        tag_id;
    logic [DATA_W-1:0] held0;
    logic [DATA_W-1:0] held1;

    logic              run_ok;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // last = 1 means c1 was granted most recently, so c0 wins the next tie
    assign run_ok    = (state == RUN) && !reset && !clear;
    assign c0_gnt    = run_ok && c0_req && (!c1_req || last);
    assign c1_gnt    = run_ok && c1_req && (!c0_req || !last);
    assign any_gnt   = c0_gnt || c1_gnt;
    assign sel_we    = c1_gnt ? c1_we    : c0_we;
    assign sel_addr  = c1_gnt ? c1_addr  : c0_addr;
    assign sel_wdata = c1_gnt ? c1_wdata : c0_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INIT;
            cnt      <= '0;
            last     <= 1'b1;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_w_q <= '0;
            addr_r_q <= '0;
            data_q   <= '0;
            tag_vld  <= '0;
            tag_id   <= '0;
            held0    <= '0;
            held1    <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (clear) begin
                        state <= INIT;
                        cnt   <= '0;
                    end
                end
                default: state <= INIT;
            endcase

            wr_q <= any_gnt && sel_we;
            rd_q <= any_gnt && !sel_we;
            if (any_gnt) begin
                last <= c1_gnt;
                if (sel_we) begin
                    addr_w_q <= sel_addr;
                    data_q   <= sel_wdata;
                end else begin
                    addr_r_q <= sel_addr;
                end
            end

            tag_vld <= {tag_vld[0], any_gnt && !sel_we};
            tag_id  <= {tag_id[0], c1_gnt};

            if (c0_rvalid)
                held0 <= mem_dataout;
            if (c1_rvalid)
                held1 <= mem_dataout;
        end
    end

    // INIT writes are gated by reset so the clear sweep begins only once reset is released
    assign busy       = (state == INIT) || reset;
    assign mem_write  = ((state == INIT) && !reset) || wr_q;
    assign mem_addr_w = (state == INIT) ? cnt : addr_w_q;
    assign mem_datain = (state == INIT) ? '0 : data_q;
    assign mem_read   = rd_q;
    assign mem_addr_r = addr_r_q;

    assign c0_rvalid  = tag_vld[1] && !tag_id[1] && !reset;
    assign c1_rvalid  = tag_vld[1] &&  tag_id[1] && !reset;
    assign c0_rdata   = c0_rvalid ? mem_dataout : held0;
    assign c1_rdata   = c1_rvalid ? mem_dataout : held1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, arbitration/memory reference model and
// a read-response scoreboard drained by an independent monitor.
module tb_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset, clear, busy;
    logic       c0_req, c1_req, c0_we, c1_we;
    logic [2:0] c0_addr, c1_addr;
    logic [7:0] c0_wdata, c1_wdata;
    logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [7:0] c0_rdata, c1_rdata;
    logic       mem_write, mem_read;
    logic [2:0] mem_addr_w, mem_addr_r;
    logic [7:0] mem_datain, mem_dataout;

    mem_arbiter #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .clear(clear), .busy(busy),
        .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
        .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
        .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr_w(mem_addr_w),
        .mem_addr_r(mem_addr_r), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    always #5 clock = ~clock;

    // behavioural memory, deliberately filled with garbage so the clear sweep matters
    logic [7:0] mem_arr [8];
    initial begin
        for (int i = 0; i < 8; i++) mem_arr[i] = 8'($urandom);
        mem_dataout = 8'hEE;
    end
    always @(posedge clock) begin
        if (mem_write) mem_arr[mem_addr_w] <= mem_datain;
        if (mem_read)  mem_dataout <= mem_arr[mem_addr_r];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // reference model state
    typedef struct { logic [7:0] d; int due; } rsp_t;
    rsp_t       q0[$], q1[$];
    logic [7:0] ref_mem [8];
    logic [7:0] last_rd [2];
    int         m_last, m_cnt, prev_kind;
    bit         m_busy, rst_prev;
    logic [2:0] prev_addr;
    logic [7:0] prev_data;
    bit         g0_s, g1_s;

    always @(negedge clock) begin
        int e;
        logic       we;
        logic [2:0] a;
        logic [7:0] d;
        g0_s = c0_gnt;
        g1_s = c1_gnt;
        if (reset) begin
            chk("busy_in_reset", busy, 1);
            chk("gnt_in_reset", {c0_gnt, c1_gnt}, 0);
            chk("rvalid_in_reset", {c0_rvalid, c1_rvalid}, 0);
            if (rst_prev) begin
                chk("mem_read_in_reset", mem_read, 0);
                chk("mem_addr_r_in_reset", mem_addr_r, 0);
                chk("rdata_in_reset", {c0_rdata, c1_rdata}, 0);
            end
            q0.delete();
            q1.delete();
            for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
            last_rd[0] = 8'h00;
            last_rd[1] = 8'h00;
            m_last = 1; m_busy = 1; m_cnt = 0; prev_kind = 0;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            chk("busy", busy, m_busy);
            chk("mem_read", mem_read, prev_kind == 2);
            if (prev_kind == 2) chk("mem_addr_r", mem_addr_r, prev_addr);
            if (m_busy) begin
                chk("gnt_while_busy", {c0_gnt, c1_gnt}, 0);
                chk("init_mem_write", mem_write, 1);
                chk("init_addr_w", mem_addr_w, m_cnt);
                chk("init_datain", mem_datain, 0);
                m_cnt++;
                if (m_cnt == 8) m_busy = 0;
                prev_kind = 0;
            end else begin
                chk("mem_write", mem_write, prev_kind == 1);
                if (prev_kind == 1) begin
                    chk("mem_addr_w", mem_addr_w, prev_addr);
                    chk("mem_datain", mem_datain, prev_data);
                end
                // winner: -1 none, else client index
                if (clear)                 e = -1;
                else if (c0_req && c1_req) e = (m_last == 1) ? 0 : 1;
                else if (c0_req)           e = 0;
                else if (c1_req)           e = 1;
                else                       e = -1;
                chk("c0_gnt", c0_gnt, e == 0);
                chk("c1_gnt", c1_gnt, e == 1);
                prev_kind = 0;
                if (clear) begin
                    m_busy = 1;
                    m_cnt  = 0;
                    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
                end else if (e >= 0) begin
                    m_last = e;
                    we = (e == 0) ? c0_we : c1_we;
                    a  = (e == 0) ? c0_addr : c1_addr;
                    d  = (e == 0) ? c0_wdata : c1_wdata;
                    prev_addr = a;
                    prev_data = d;
                    if (we) begin
                        ref_mem[a] = d;
                        prev_kind  = 1;
                    end else begin
                        prev_kind = 2;
                        if (e == 0) q0.push_back('{ref_mem[a], cyc + 2});
                        else        q1.push_back('{ref_mem[a], cyc + 2});
                    end
                end
            end
        end
    end

    // response monitor: pops the scoreboard whenever a client sees rvalid
    task automatic mon(input int c, input logic rv, input logic [7:0] rd);
        rsp_t r;
        int   n;
        n = (c == 0) ? q0.size() : q1.size();
        if (rv) begin
            if (n == 0) begin
                checks++; errors++;
                $display("FAIL spurious_rvalid client %0d at cycle %0d: rvalid=1, expected 0", c, cyc);
            end else begin
                r = (c == 0) ? q0.pop_front() : q1.pop_front();
                chk(c == 0 ? "c0_rdata" : "c1_rdata", rd, r.d);
                chk(c == 0 ? "c0_rvalid_cycle" : "c1_rvalid_cycle", cyc, r.due);
                last_rd[c] = r.d;
            end
        end else begin
            chk(c == 0 ? "c0_rdata_held" : "c1_rdata_held", rd, last_rd[c]);
            if (n > 0) begin
                r = (c == 0) ? q0[0] : q1[0];
                if (r.due < cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_rvalid client %0d at cycle %0d: rvalid=0, expected 1 at cycle %0d", c, cyc, r.due);
                    if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            mon(0, c0_rvalid, c0_rdata);
            mon(1, c1_rvalid, c1_rdata);
            chk("one_command", {mem_write && mem_read && !busy}, 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req_one(input int c, input logic we, input logic [2:0] a, input logic [7:0] d);
        bit done = 0;
        if (c == 0) begin c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = d; end
        else        begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d; end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            done = (c == 0) ? c0_gnt : c1_gnt;
            tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL grant_timeout client %0d: no grant, expected one within 20 cycles", c);
        end
        if (c == 0) c0_req = 0; else c1_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1; clear = 0;
        c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
        c0_addr = 0; c1_addr = 0; c0_wdata = 0; c1_wdata = 0;
        tick(); tick();
        reset = 0;

        // after the clear sweep, address 3 reads as zero
        req_one(1, 0, 3'd3, 8'h00);

        // fairness: both requesting, c0 wins the first tie after a c1 grant
        c0_we = 0; c1_we = 0; c0_addr = 3'd1; c1_addr = 3'd6;
        c0_req = 1; c1_req = 1;
        repeat (6) tick();
        c0_req = 0; c1_req = 0;

        // single client write then read
        req_one(0, 1, 3'd5, 8'h55);
        req_one(0, 0, 3'd5, 8'h00);
        repeat (3) tick();

        // cross-client read-after-write
        req_one(1, 1, 3'd7, 8'hA7);
        req_one(0, 0, 3'd7, 8'h00);
        repeat (3) tick();

        // clear with a read in flight and c1 waiting
        req_one(0, 1, 3'd2, 8'h44);
        req_one(0, 0, 3'd2, 8'h00);
        clear = 1; c1_req = 1; c1_we = 0; c1_addr = 3'd2;
        tick();
        clear = 0;
        req_one(1, 0, 3'd2, 8'h00);
        repeat (3) tick();

        // reset in the middle of INIT
        clear = 1;
        tick();
        clear = 0;
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;

        // read granted then reset: its response must never appear
        req_one(0, 0, 3'd1, 8'h00);
        reset = 1;
        tick();
        reset = 0;
        repeat (12) tick();

        // randomized traffic with occasional clear and reset
        for (int n = 0; n < 400; n++) begin
            if (!c0_req || g0_s) begin
                c0_req = ($urandom_range(0, 2) != 0);
                c0_we = 1'($urandom); c0_addr = 3'($urandom); c0_wdata = 8'($urandom);
            end
            if (!c1_req || g1_s) begin
                c1_req = ($urandom_range(0, 2) != 0);
                c1_we = 1'($urandom); c1_addr = 3'($urandom); c1_wdata = 8'($urandom);
            end
            clear = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        c0_req = 0; c1_req = 0; clear = 0; reset = 0;
        repeat (12) tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
